// File: rtl/fetch_buffer_2w_if.sv
// Fetch-stage bundle: cache request/response, squash redirect and the 2-wide decode window.
interface fetch_buffer_2w_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
);
    logic                          squash;
    logic [XLEN-1:0]               squash_pc;
    logic [63:0]                   Icache_data_out;
    logic                          Icache_valid_out;
    logic [XLEN-1:0]               proc2Icache_addr;
    logic [1:0]                    id_take;
    logic [1:0]                    if_valid;
    logic [1:0][31:0]              if_inst;
    logic [1:0][XLEN-1:0]          if_pc;
    logic [$clog2(DEPTH):0]        fb_count;

    modport master (
        output squash, squash_pc, Icache_data_out, Icache_valid_out, id_take,
        input  proc2Icache_addr, if_valid, if_inst, if_pc, fb_count
    );

    modport slave (
        input  squash, squash_pc, Icache_data_out, Icache_valid_out, id_take,
        output proc2Icache_addr, if_valid, if_inst, if_pc, fb_count
    );
endinterface

// File: rtl/fetch_buffer_2w.sv
// Fetch PC + circular instruction FIFO: splits 64-bit cache lines into two tagged
// 32-bit instructions and presents up to two per cycle to decode.
module fetch_buffer_2w #(
    parameter int unsigned   XLEN     = 32,
    parameter int unsigned   DEPTH    = 8,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic               clock,
    input  logic               reset,
    fetch_buffer_2w_if.slave   bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     inst_q [DEPTH];
    logic [31:0]     inst_d [DEPTH];
    logic [XLEN-1:0] pcs_q  [DEPTH];
    logic [XLEN-1:0] pcs_d  [DEPTH];

    logic [XLEN-1:0] pc_al;
    logic [CW-1:0]   n_push;
    logic [CW-1:0]   free_slots;
    logic            do_push;
    logic [CW-1:0]   pushed;
    logic [CW-1:0]   take_c;
    logic [CW-1:0]   popped;
    logic [PW-1:0]   tail_p1;
    logic [PW-1:0]   head_p1;

    assign pc_al      = {fetch_pc_q[XLEN-1:3], 3'b000};
    assign n_push     = fetch_pc_q[2] ? CW'(1) : CW'(2);
    // Free space deliberately ignores same-cycle pops to keep the push decision off id_take.
    assign free_slots = CW'(DEPTH) - count_q;
    assign do_push    = bus.Icache_valid_out && !bus.squash && (free_slots >= n_push);
    assign pushed     = do_push ? n_push : '0;
    assign take_c     = (bus.id_take == 2'd0) ? CW'(0) :
                        (bus.id_take == 2'd1) ? CW'(1) : CW'(2);
    assign popped     = (take_c > count_q) ? count_q : take_c;
    assign tail_p1    = tail_q + PW'(1);
    assign head_p1    = head_q + PW'(1);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inst_d     = inst_q;
        pcs_d      = pcs_q;
        if (bus.squash) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            fetch_pc_d = {bus.squash_pc[XLEN-1:2], 2'b00};
        end else begin
            if (do_push) begin
                if (fetch_pc_q[2]) begin
                    inst_d[tail_q] = bus.Icache_data_out[63:32];
                    pcs_d[tail_q]  = fetch_pc_q;
                end else begin
                    inst_d[tail_q]  = bus.Icache_data_out[31:0];
                    pcs_d[tail_q]   = pc_al;
                    inst_d[tail_p1] = bus.Icache_data_out[63:32];
                    pcs_d[tail_p1]  = pc_al + XLEN'(4);
                end
                tail_d     = tail_q + PW'(n_push);
                fetch_pc_d = pc_al + XLEN'(8);
            end
            head_d  = head_q + PW'(popped);
            count_d = count_q + pushed - popped;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= PC_RESET;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inst_q     <= '{default: '0};
            pcs_q      <= '{default: '0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inst_q     <= inst_d;
            pcs_q      <= pcs_d;
        end
    end

    logic v0, v1;
    assign v0 = (count_q >= CW'(1));
    assign v1 = (count_q >= CW'(2));

    assign bus.proc2Icache_addr = {fetch_pc_q[XLEN-1:3], 3'b000};
    assign bus.fb_count         = count_q;
    assign bus.if_valid         = {v1, v0};
    assign bus.if_inst[0]       = v0 ? inst_q[head_q]  : '0;
    assign bus.if_inst[1]       = v1 ? inst_q[head_p1] : '0;
    assign bus.if_pc[0]         = v0 ? pcs_q[head_q]   : '0;
    assign bus.if_pc[1]         = v1 ? pcs_q[head_p1]  : '0;
endmodule

// File: tb/tb_fetch_buffer_2w.sv
// Directed bench for fetch_buffer_2w: fill, full stall, squash redirect, drain, async reset.
module tb_fetch_buffer_2w;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;

    fetch_buffer_2w_if #(.XLEN(32), .DEPTH(8)) bus ();

    fetch_buffer_2w #(.XLEN(32), .DEPTH(8), .PC_RESET(32'h0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Cache model: every line hits; low word tags 0x1000_0000|addr, high word 0x2000_0000|(addr+4).
    assign bus.Icache_data_out = {32'h2000_0000 | (bus.proc2Icache_addr + 32'd4),
                                  32'h1000_0000 | bus.proc2Icache_addr};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.squash = 1'b0;
        bus.squash_pc = '0;
        bus.Icache_valid_out = 1'b0;
        bus.id_take = 2'd0;
        #12;
        chk("rst_valid", 64'(bus.if_valid), 64'h0);
        chk("rst_count", 64'(bus.fb_count), 64'h0);
        chk("rst_addr",  64'(bus.proc2Icache_addr), 64'h0);
        chk("rst_inst0", 64'(bus.if_inst[0]), 64'h0);
        chk("rst_pc0",   64'(bus.if_pc[0]), 64'h0);
        reset = 1'b0;

        // Fill with no consumption
        bus.Icache_valid_out = 1'b1;
        step();
        chk("f1_count", 64'(bus.fb_count), 64'd2);
        chk("f1_addr",  64'(bus.proc2Icache_addr), 64'h8);
        chk("f1_valid", 64'(bus.if_valid), 64'h3);
        chk("f1_inst0", 64'(bus.if_inst[0]), 64'h1000_0000);
        chk("f1_pc0",   64'(bus.if_pc[0]), 64'h0);
        chk("f1_inst1", 64'(bus.if_inst[1]), 64'h2000_0004);
        chk("f1_pc1",   64'(bus.if_pc[1]), 64'h4);
        step();
        chk("f2_count", 64'(bus.fb_count), 64'd4);
        chk("f2_addr",  64'(bus.proc2Icache_addr), 64'h10);
        step();
        chk("f3_count", 64'(bus.fb_count), 64'd6);
        chk("f3_addr",  64'(bus.proc2Icache_addr), 64'h18);
        step();
        chk("f4_count", 64'(bus.fb_count), 64'd8);
        chk("f4_addr",  64'(bus.proc2Icache_addr), 64'h20);
        step();
        chk("stall_count", 64'(bus.fb_count), 64'd8);
        chk("stall_addr",  64'(bus.proc2Icache_addr), 64'h20);

        // Full with pop: start-of-cycle count blocks the push
        bus.id_take = 2'd2;
        step();
        chk("fullpop_count", 64'(bus.fb_count), 64'd6);
        chk("fullpop_addr",  64'(bus.proc2Icache_addr), 64'h20);
        chk("fullpop_pc0",   64'(bus.if_pc[0]), 64'h8);
        chk("fullpop_inst0", 64'(bus.if_inst[0]), 64'h1000_0008);
        step();
        chk("resume_count", 64'(bus.fb_count), 64'd6);
        chk("resume_addr",  64'(bus.proc2Icache_addr), 64'h28);
        chk("resume_pc0",   64'(bus.if_pc[0]), 64'h10);

        // Squash with low bits set; hit and take that cycle are ignored
        bus.squash = 1'b1;
        bus.squash_pc = 32'h0000_0107;
        step();
        chk("sq_count", 64'(bus.fb_count), 64'd0);
        chk("sq_valid", 64'(bus.if_valid), 64'h0);
        chk("sq_addr",  64'(bus.proc2Icache_addr), 64'h100);
        bus.squash = 1'b0;
        bus.id_take = 2'd0;
        step();
        chk("mis_count", 64'(bus.fb_count), 64'd1);
        chk("mis_valid", 64'(bus.if_valid), 64'h1);
        chk("mis_pc0",   64'(bus.if_pc[0]), 64'h104);
        chk("mis_inst0", 64'(bus.if_inst[0]), 64'h2000_0104);
        chk("mis_addr",  64'(bus.proc2Icache_addr), 64'h108);
        step();
        chk("odd_count", 64'(bus.fb_count), 64'd3);
        chk("odd_addr",  64'(bus.proc2Icache_addr), 64'h110);

        // Miss window: drain, id_take=3 clamps to 2 then to the occupancy
        bus.Icache_valid_out = 1'b0;
        bus.id_take = 2'd3;
        step();
        chk("dr1_count", 64'(bus.fb_count), 64'd1);
        chk("dr1_valid", 64'(bus.if_valid), 64'h1);
        chk("dr1_pc0",   64'(bus.if_pc[0]), 64'h10C);
        chk("dr1_inst0", 64'(bus.if_inst[0]), 64'h2000_010C);
        chk("dr1_addr",  64'(bus.proc2Icache_addr), 64'h110);
        step();
        chk("dr2_count", 64'(bus.fb_count), 64'd0);
        chk("dr2_valid", 64'(bus.if_valid), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dr_idle_count", 64'(bus.fb_count), 64'd0);
            chk("dr_idle_addr",  64'(bus.proc2Icache_addr), 64'h110);
        end

        // Build count=5, then reset asynchronously mid-cycle
        bus.id_take = 2'd0;
        bus.Icache_valid_out = 1'b1;
        step();
        step();
        step();
        chk("pre_count6", 64'(bus.fb_count), 64'd6);
        chk("pre_pc0",    64'(bus.if_pc[0]), 64'h110);
        bus.Icache_valid_out = 1'b0;
        bus.id_take = 2'd1;
        step();
        chk("pre_count5", 64'(bus.fb_count), 64'd5);
        chk("pre_addr",   64'(bus.proc2Icache_addr), 64'h128);
        reset = 1'b1;
        #1;
        chk("arst_count", 64'(bus.fb_count), 64'd0);
        chk("arst_valid", 64'(bus.if_valid), 64'h0);
        chk("arst_addr",  64'(bus.proc2Icache_addr), 64'h0);
        #1;
        reset = 1'b0;
        bus.id_take = 2'd0;
        bus.Icache_valid_out = 1'b1;
        step();
        chk("post_count", 64'(bus.fb_count), 64'd2);
        chk("post_addr",  64'(bus.proc2Icache_addr), 64'h8);
        chk("post_pc1",   64'(bus.if_pc[1]), 64'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
